// File: rtl/link_reset_sequencer_if.sv
// Reset-sequencer link interface.
// master: the sequencer (consumes PLL lock / channel-up / restart, drives resets and status).
// slave : the link side (transceiver/core/software), the mirror image of master.
//   pll_lock, channel_up, manual_reset : link status and software restart into the sequencer
//   gt_reset, core_reset               : active-high resets to the GT and Aurora core
//   link_ready, state, retry_count     : status out of the sequencer
interface link_reset_sequencer_if;
  logic       pll_lock;
  logic       channel_up;
  logic       manual_reset;
  logic       gt_reset;
  logic       core_reset;
  logic       link_ready;
  logic [2:0] state;
  logic [7:0] retry_count;

  modport master (
    input  pll_lock, channel_up, manual_reset,
    output gt_reset, core_reset, link_ready, state, retry_count
  );

  modport slave (
    output pll_lock, channel_up, manual_reset,
    input  gt_reset, core_reset, link_ready, state, retry_count
  );
endinterface

// File: rtl/link_reset_sequencer.sv
// Serial-link reset sequencer: GT reset, wait for PLL lock, core reset, wait for
// channel-up, then RUN. Restarts on timeout, lock loss or filtered link loss and
// keeps a saturating retry count.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : link_reset_sequencer_if.master (lock/up/restart in, resets/status out)
module link_reset_sequencer #(
  parameter int unsigned GT_RST_CYCLES   = 16,
  parameter int unsigned CORE_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT    = 1024,
  parameter int unsigned UP_TIMEOUT      = 65536,
  parameter int unsigned DROP_FILTER     = 8,
  parameter int unsigned CNT_W           = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  link_reset_sequencer_if.master bus
);

  localparam int unsigned DROP_W = $clog2(DROP_FILTER + 1);

  localparam logic [2:0] ST_GT_RST    = 3'd0;
  localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [2:0] ST_CORE_RST  = 3'd2;
  localparam logic [2:0] ST_WAIT_UP   = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;

  localparam logic [CNT_W-1:0]  GT_LAST    = CNT_W'(GT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CORE_LAST  = CNT_W'(CORE_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  UP_LAST    = CNT_W'(UP_TIMEOUT - 1);
  localparam logic [DROP_W-1:0] DROP_LAST  = DROP_W'(DROP_FILTER - 1);
  localparam logic [7:0]        RETRY_MAX  = 8'hFF;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  timer_q;
  logic [DROP_W-1:0] drop_q;
  logic [7:0]        retry_q;
  logic              take;       // a transition (or re-entry) happens this cycle
  logic              retry_inc;  // that transition is an automatic restart
  logic              drop_hit;

  // The DROP_FILTER-th consecutive low sample: counter already holds DROP_FILTER-1.
  assign drop_hit = !bus.channel_up && (drop_q == DROP_LAST);

  // State, timer, drop filter and retry registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_GT_RST;
      timer_q <= '0;
      drop_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= take ? '0 : timer_q + CNT_W'(1);
      if (take || state_q != ST_RUN || bus.channel_up) begin
        drop_q <= '0;
      end else begin
        drop_q <= drop_q + DROP_W'(1);
      end
      if (retry_inc && retry_q != RETRY_MAX) begin
        retry_q <= retry_q + 8'd1;
      end
    end
  end

  // Next-state logic; manual restart overrides everything below rst.
  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    retry_inc = 1'b0;
    case (state_q)
      ST_GT_RST: begin
        if (timer_q == GT_LAST) begin
          state_d = ST_WAIT_LOCK;
          take    = 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        if (bus.pll_lock) begin
          state_d = ST_CORE_RST;
          take    = 1'b1;
        end else if (timer_q == LOCK_LAST) begin
          state_d   = ST_GT_RST;
          take      = 1'b1;
          retry_inc = 1'b1;
        end
      end
      ST_CORE_RST: begin
        if (!bus.pll_lock) begin
          state_d   = ST_GT_RST;
          take      = 1'b1;
          retry_inc = 1'b1;
        end else if (timer_q == CORE_LAST) begin
          state_d = ST_WAIT_UP;
          take    = 1'b1;
        end
      end
      ST_WAIT_UP: begin
        if (!bus.pll_lock) begin
          state_d   = ST_GT_RST;
          take      = 1'b1;
          retry_inc = 1'b1;
        end else if (bus.channel_up) begin
          state_d = ST_RUN;
          take    = 1'b1;
        end else if (timer_q == UP_LAST) begin
          state_d   = ST_GT_RST;
          take      = 1'b1;
          retry_inc = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.pll_lock) begin
          state_d   = ST_GT_RST;
          take      = 1'b1;
          retry_inc = 1'b1;
        end else if (drop_hit) begin
          // Core-only restart: the GT is still locked, so leave it alone.
          state_d   = ST_CORE_RST;
          take      = 1'b1;
          retry_inc = 1'b1;
        end
      end
      default: begin
        state_d = ST_GT_RST;
        take    = 1'b1;
      end
    endcase
    // Held manual_reset re-enters GT_RST each cycle, pinning the timer at 0.
    if (bus.manual_reset) begin
      state_d   = ST_GT_RST;
      take      = 1'b1;
      retry_inc = 1'b0;
    end
  end

  // Moore outputs decoded from the registered state only.
  always_comb begin
    bus.state       = state_q;
    bus.retry_count = retry_q;
    bus.gt_reset    = (state_q == ST_GT_RST);
    bus.core_reset  = (state_q == ST_GT_RST) || (state_q == ST_WAIT_LOCK) ||
                      (state_q == ST_CORE_RST);
    bus.link_ready  = (state_q == ST_RUN);
  end

endmodule

// File: tb/tb_link_reset_sequencer.sv
// Directed bench for link_reset_sequencer: a default-parameter instance for the
// bring-up, filter, restart and boundary scenarios, and a short-timeout instance
// for retry saturation.
module tb_link_reset_sequencer;

  logic clk;
  logic rst;
  logic rst2;
  int   total;
  int   bad;

  link_reset_sequencer_if bus_a ();
  link_reset_sequencer_if bus_b ();

  link_reset_sequencer dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );

  link_reset_sequencer #(
    .GT_RST_CYCLES (2),
    .LOCK_TIMEOUT  (4)
  ) dut_b (
    .clk (clk),
    .rst (rst2),
    .bus (bus_b.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      ok = (bus_a.state == s);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rst2 = 1'b1;
    bus_a.pll_lock = 1'b0; bus_a.channel_up = 1'b0; bus_a.manual_reset = 1'b0;
    bus_b.pll_lock = 1'b0; bus_b.channel_up = 1'b0; bus_b.manual_reset = 1'b0;
    repeat (4) tick();
    total++; if (bus_a.state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", bus_a.state); end
    total++; if (bus_a.gt_reset !== 1'b1) begin bad++; $display("FAIL reset_gt: got %b want 1", bus_a.gt_reset); end
    total++; if (bus_a.core_reset !== 1'b1) begin bad++; $display("FAIL reset_core: got %b want 1", bus_a.core_reset); end
    total++; if (bus_a.link_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus_a.link_ready); end
    total++; if (bus_a.retry_count !== 8'd0) begin bad++; $display("FAIL reset_retry: got %0d want 0", bus_a.retry_count); end
  endtask

  // GT_RST=2, LOCK_TIMEOUT=4 with no lock: one automatic restart every 6 cycles.
  task automatic test_saturation();
    rst2 = 1'b0;
    repeat (6 * 254 + 3) tick();
    total++; if (bus_b.retry_count !== 8'd254) begin bad++; $display("FAIL sat_254: got %0d want 254", bus_b.retry_count); end
    repeat (6) tick();
    total++; if (bus_b.retry_count !== 8'd255) begin bad++; $display("FAIL sat_255: got %0d want 255", bus_b.retry_count); end
    repeat (6 * 5) tick();
    total++; if (bus_b.retry_count !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", bus_b.retry_count); end
  endtask

  task automatic test_bring_up();
    int n;
    rst = 1'b0;
    n = 0;
    while (bus_a.gt_reset && n < 64) begin n++; tick(); end
    total++; if (n !== 16) begin bad++; $display("FAIL up_gt_len: got %0d want 16", n); end
    total++; if (bus_a.state !== 3'd1) begin bad++; $display("FAIL up_wait_lock: got %0d want 1", bus_a.state); end
    repeat (14) tick();
    bus_a.pll_lock = 1'b1;
    tick();
    total++; if (bus_a.state !== 3'd2) begin bad++; $display("FAIL up_core_rst: got %0d want 2", bus_a.state); end
    n = 0;
    while (bus_a.state == 3'd2 && n < 64) begin n++; tick(); end
    total++; if (n !== 16) begin bad++; $display("FAIL up_core_len: got %0d want 16", n); end
    total++; if (bus_a.state !== 3'd3) begin bad++; $display("FAIL up_wait_up: got %0d want 3", bus_a.state); end
    total++; if (bus_a.core_reset !== 1'b0) begin bad++; $display("FAIL up_core_low: got %b want 0", bus_a.core_reset); end
    repeat (99) tick();
    total++; if (bus_a.link_ready !== 1'b0) begin bad++; $display("FAIL up_not_ready: got %b want 0", bus_a.link_ready); end
    bus_a.channel_up = 1'b1;
    tick();
    total++; if (bus_a.state !== 3'd4) begin bad++; $display("FAIL up_run: got %0d want 4", bus_a.state); end
    total++; if (bus_a.link_ready !== 1'b1) begin bad++; $display("FAIL up_ready: got %b want 1", bus_a.link_ready); end
    total++; if (bus_a.retry_count !== 8'd0) begin bad++; $display("FAIL up_retry: got %0d want 0", bus_a.retry_count); end
  endtask

  task automatic test_glitch_filter();
    bit left;
    bit ok;
    bus_a.channel_up = 1'b0;
    repeat (7) tick();
    bus_a.channel_up = 1'b1;
    tick();
    total++; if (bus_a.state !== 3'd4) begin bad++; $display("FAIL glitch7_state: got %0d want 4", bus_a.state); end
    total++; if (bus_a.retry_count !== 8'd0) begin bad++; $display("FAIL glitch7_retry: got %0d want 0", bus_a.retry_count); end
    repeat (3) tick();
    bus_a.channel_up = 1'b0;
    left = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (bus_a.state != 3'd4) left = 1'b1;
    end
    total++; if (left !== 1'b0) begin bad++; $display("FAIL glitch8_early: got %b want 0", left); end
    tick();
    total++; if (bus_a.state !== 3'd2) begin bad++; $display("FAIL glitch8_state: got %0d want 2", bus_a.state); end
    total++; if (bus_a.gt_reset !== 1'b0) begin bad++; $display("FAIL glitch8_gt: got %b want 0", bus_a.gt_reset); end
    total++; if (bus_a.retry_count !== 8'd1) begin bad++; $display("FAIL glitch8_retry: got %0d want 1", bus_a.retry_count); end
    bus_a.channel_up = 1'b1;
    wait_state(3'd4, 64, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL glitch_rerun: got %b want 1", ok); end
  endtask

  task automatic test_lock_loss_manual();
    bit ok;
    int n;
    bus_a.pll_lock = 1'b0;
    tick();
    total++; if (bus_a.state !== 3'd0) begin bad++; $display("FAIL lockloss_state: got %0d want 0", bus_a.state); end
    total++; if (bus_a.retry_count !== 8'd2) begin bad++; $display("FAIL lockloss_retry: got %0d want 2", bus_a.retry_count); end
    bus_a.pll_lock = 1'b1;
    wait_state(3'd4, 100, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL lockloss_rerun: got %b want 1", ok); end
    bus_a.manual_reset = 1'b1;
    tick();
    bus_a.manual_reset = 1'b0;
    total++; if (bus_a.state !== 3'd0) begin bad++; $display("FAIL manual_state: got %0d want 0", bus_a.state); end
    total++; if (bus_a.retry_count !== 8'd2) begin bad++; $display("FAIL manual_retry: got %0d want 2", bus_a.retry_count); end
    wait_state(3'd4, 100, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL manual_rerun: got %b want 1", ok); end
    // Cycles from manual_reset assertion (held 5) until gt_reset is seen low: 5 + 16.
    bus_a.manual_reset = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 5) bus_a.manual_reset = 1'b0;
    end while (bus_a.gt_reset && n < 64);
    total++; if (n !== 21) begin bad++; $display("FAIL manual_held_len: got %0d want 21", n); end
    wait_state(3'd4, 100, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL manual_held_rerun: got %b want 1", ok); end
  endtask

  task automatic test_lock_timeout();
    bit ok;
    int n;
    bus_a.pll_lock = 1'b0;
    bus_a.manual_reset = 1'b1;
    tick();
    bus_a.manual_reset = 1'b0;
    wait_state(3'd1, 64, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL to_enter: got %b want 1", ok); end
    n = 0;
    while (bus_a.state == 3'd1 && n < 2000) begin n++; tick(); end
    total++; if (n !== 1024) begin bad++; $display("FAIL to_len1: got %0d want 1024", n); end
    total++; if (bus_a.retry_count !== 8'd3) begin bad++; $display("FAIL to_retry1: got %0d want 3", bus_a.retry_count); end
    n = 0;
    while (bus_a.gt_reset && n < 64) begin n++; tick(); end
    total++; if (n !== 16) begin bad++; $display("FAIL to_gt_len: got %0d want 16", n); end
    n = 0;
    while (bus_a.state == 3'd1 && n < 2000) begin n++; tick(); end
    total++; if (n !== 1024) begin bad++; $display("FAIL to_len2: got %0d want 1024", n); end
    total++; if (bus_a.retry_count !== 8'd4) begin bad++; $display("FAIL to_retry2: got %0d want 4", bus_a.retry_count); end
  endtask

  task automatic test_lock_boundary();
    bit ok;
    bus_a.channel_up = 1'b0;
    wait_state(3'd1, 64, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL lb_enter: got %b want 1", ok); end
    repeat (1023) tick();
    total++; if (bus_a.state !== 3'd1) begin bad++; $display("FAIL lb_before: got %0d want 1", bus_a.state); end
    bus_a.pll_lock = 1'b1;
    tick();
    total++; if (bus_a.state !== 3'd2) begin bad++; $display("FAIL lb_state: got %0d want 2", bus_a.state); end
    total++; if (bus_a.retry_count !== 8'd4) begin bad++; $display("FAIL lb_retry: got %0d want 4", bus_a.retry_count); end
  endtask

  task automatic test_up_boundary();
    bit ok;
    wait_state(3'd3, 64, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL ub_enter: got %b want 1", ok); end
    repeat (65535) tick();
    total++; if (bus_a.state !== 3'd3) begin bad++; $display("FAIL ub_before: got %0d want 3", bus_a.state); end
    bus_a.channel_up = 1'b1;
    tick();
    total++; if (bus_a.state !== 3'd4) begin bad++; $display("FAIL ub_state: got %0d want 4", bus_a.state); end
    total++; if (bus_a.retry_count !== 8'd4) begin bad++; $display("FAIL ub_retry: got %0d want 4", bus_a.retry_count); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    bus_a.channel_up = 1'b0;
    bus_a.manual_reset = 1'b1;
    tick();
    bus_a.manual_reset = 1'b0;
    wait_state(3'd3, 64, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL mr_enter: got %b want 1", ok); end
    repeat (5) tick();
    rst = 1'b1;
    bus_a.manual_reset = 1'b1;
    tick();
    total++; if (bus_a.state !== 3'd0) begin bad++; $display("FAIL mr_state: got %0d want 0", bus_a.state); end
    total++; if (bus_a.retry_count !== 8'd0) begin bad++; $display("FAIL mr_retry: got %0d want 0", bus_a.retry_count); end
    total++; if (bus_a.gt_reset !== 1'b1) begin bad++; $display("FAIL mr_gt: got %b want 1", bus_a.gt_reset); end
    total++; if (bus_a.core_reset !== 1'b1) begin bad++; $display("FAIL mr_core: got %b want 1", bus_a.core_reset); end
    total++; if (bus_a.link_ready !== 1'b0) begin bad++; $display("FAIL mr_ready: got %b want 0", bus_a.link_ready); end
    bus_a.manual_reset = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_saturation();
    test_bring_up();
    test_glitch_filter();
    test_lock_loss_manual();
    test_lock_timeout();
    test_lock_boundary();
    test_up_boundary();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/link_reset_sequencer.md
Name: link_reset_sequencer

Overview:
- Drives the reset side of a serial link: sequences transceiver reset, then core reset, and waits for PLL lock and channel-up.
- Re-issues resets on timeout or link loss and counts retries.
- Sits between the board-level reset (already stretched upstream) and the Aurora core/GT reset pins.
- Exports link_ready to downstream logic.

Parameters:
- GT_RST_CYCLES, 16, cycles gt_reset is held in GT_RST state (>=2)
- CORE_RST_CYCLES, 16, cycles core_reset is held in CORE_RST state (>=2)
- LOCK_TIMEOUT, 1024, cycles allowed in WAIT_LOCK before retry
- UP_TIMEOUT, 65536, cycles allowed in WAIT_UP before retry
- DROP_FILTER, 8, consecutive channel_up-low cycles in RUN treated as link loss
- CNT_W, 17, shared timer width; must hold max(all cycle parameters)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- pll_lock  in  1  GT PLL lock, synchronous to clk
- channel_up  in  1  Aurora channel up, synchronous to clk
- manual_reset  in  1  single-cycle software restart request
- gt_reset  out  1  transceiver reset, active-high
- core_reset  out  1  Aurora core reset, active-high
- link_ready  out  1  high only in RUN
- state  out  3  current state code
- retry_count  out  8  saturating count of automatic restarts

Behaviour:
- State codes: GT_RST=0, WAIT_LOCK=1, CORE_RST=2, WAIT_UP=3, RUN=4; codes 5-7 are illegal and go to GT_RST on the next cycle.
- Moore machine; outputs are decoded from the registered state, so there is no combinational path from inputs to outputs.
  - gt_reset = (state==GT_RST).
  - core_reset = (state in GT_RST, WAIT_LOCK, CORE_RST).
  - link_ready = (state==RUN).
- Reset, while rst=1:
  - state=GT_RST, timer=0, drop counter=0, retry_count=0.
  - gt_reset=1, core_reset=1, link_ready=0.
- Timer: a single CNT_W counter, cleared to 0 on every state entry (including re-entry) and incremented each cycle otherwise.
- Transition priority, highest first: rst > manual_reset > pll_lock loss > state-specific transition > timeout.
- manual_reset=1 in any state: go to GT_RST; retry_count unchanged.
- GT_RST: when timer==GT_RST_CYCLES-1, go to WAIT_LOCK. gt_reset is therefore high exactly GT_RST_CYCLES cycles after rst falls.
- WAIT_LOCK:
  - pll_lock=1: go to CORE_RST. Lock wins over timeout when both occur in the same cycle.
  - Otherwise, when timer==LOCK_TIMEOUT-1: go to GT_RST and increment retry_count.
- CORE_RST:
  - pll_lock=0: go to GT_RST and increment retry_count.
  - Otherwise, when timer==CORE_RST_CYCLES-1: go to WAIT_UP.
- WAIT_UP:
  - pll_lock=0: go to GT_RST and increment retry_count.
  - channel_up=1: go to RUN.
  - Otherwise, when timer==UP_TIMEOUT-1: go to GT_RST and increment retry_count.
- RUN:
  - pll_lock=0: go to GT_RST and increment retry_count.
  - Drop counter increments while channel_up=0 and clears whenever channel_up=1.
  - When the drop counter reaches DROP_FILTER (i.e. the DROP_FILTER-th consecutive low cycle): go to CORE_RST (core-only restart; gt_reset stays low) and increment retry_count.
  - The drop counter clears on entry to RUN.
- retry_count saturates at 255, never wraps, and is cleared only by rst.
- manual_reset while rst=1 is ignored.
- manual_reset held high for multiple cycles keeps the machine in GT_RST with the timer at 0. The GT_RST countdown starts on the first cycle manual_reset is low.

Test Plan:
- Nominal bring-up: rst high 4 cycles then low; pll_lock rises at cycle 30; channel_up rises 100 cycles after core_reset falls.
  - gt_reset high exactly 16 cycles after rst falls.
  - core_reset falls exactly 16 cycles after pll_lock is seen.
  - link_ready rises 1 cycle after channel_up.
  - retry_count=0; state sequence 0,1,2,3,4.
- Lock timeout: pll_lock held 0.
  - Returns to GT_RST after 1024 cycles in WAIT_LOCK.
  - retry_count increments to 1, then 2 after the next 16+1024 cycles.
  - gt_reset pulses 16 cycles each time.
- Glitch filter in RUN:
  - channel_up low for 7 cycles: state stays 4, no retry.
  - channel_up low for 8 cycles: CORE_RST entered on the cycle after the 8th low sample, gt_reset stays 0, retry_count +1.
- Lock loss and manual restart:
  - pll_lock falls in RUN: state 0 next cycle, retry +1.
  - manual_reset pulse in RUN: state 0 next cycle, retry unchanged.
  - manual_reset held 5 cycles: gt_reset high 5+16 cycles.
- Simultaneous events and timer boundary:
  - pll_lock rises on the cycle timer==LOCK_TIMEOUT-1: go to CORE_RST, no retry.
  - channel_up rises on the cycle timer==UP_TIMEOUT-1: go to RUN.
- Saturation and mid-operation reset:
  - Force 260 lock timeouts (LOCK_TIMEOUT overridden to 4): retry_count holds at 255.
  - Assert rst in WAIT_UP: next cycle state=0, retry_count=0, gt_reset=core_reset=1.
